// File: rtl/dds_multichannel_core.sv
// Time-multiplexed multi-channel DDS core with double-buffered
// per-channel settings and a valid/ready sample stream.
module dds_multichannel_core #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 24,
    parameter int SAMPLE_W = 12,
    parameter int AMP_W    = 11,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_addr,
    input  logic [ACC_W-1:0]    cfg_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_last,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int MID = 1 << (SAMPLE_W - 1);
    localparam int PW  = SAMPLE_W + AMP_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CH_W-1:0]     ch;
    logic [ACC_W-1:0]    acc      [CHANNELS];
    logic [ACC_W-1:0]    sh_tw    [CHANNELS];
    logic [SAMPLE_W-1:0] sh_off   [CHANNELS];
    logic [AMP_W-1:0]    sh_amp   [CHANNELS];
    logic [1:0]          sh_shape [CHANNELS];
    logic [SAMPLE_W-1:0] act_off  [CHANNELS];
    logic [AMP_W-1:0]    act_amp  [CHANNELS];
    logic [1:0]          act_shape[CHANNELS];

    logic tick_ok;
    logic xfer;
    logic last_ch;
    logic cfg_hit;

    logic [SAMPLE_W-1:0]   phase;
    logic [SAMPLE_W-2:0]   tri_t;
    logic [SAMPLE_W-1:0]   wave;
    logic signed [SAMPLE_W:0] dev;
    logic signed [PW-1:0]  prod;
    logic [SAMPLE_W-1:0]   sample_nx;

    assign tick_ok = sample_tick && (state == IDLE);
    assign xfer    = (state == EMIT) && out_ready;
    assign last_ch = (ch == CH_W'(CHANNELS - 1));
    assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));

    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && (out_ch == CH_W'(CHANNELS - 1));

    // Shadow bank: written by control, copied to active only on a tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sh_tw[i]    <= '0;
                sh_off[i]   <= '0;
                sh_amp[i]   <= '0;
                sh_shape[i] <= '0;
            end
        end else if (cfg_hit) begin
            case (cfg_addr)
                2'd0: sh_tw[cfg_ch]    <= cfg_data;
                2'd1: sh_off[cfg_ch]   <= cfg_data[SAMPLE_W-1:0];
                2'd2: sh_amp[cfg_ch]   <= cfg_data[AMP_W-1:0];
                2'd3: sh_shape[cfg_ch] <= cfg_data[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]       <= '0;
                act_off[i]   <= '0;
                act_amp[i]   <= '0;
                act_shape[i] <= '0;
            end
        end else if (tick_ok) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]       <= acc[i] + sh_tw[i];
                act_off[i]   <= sh_off[i];
                act_amp[i]   <= sh_amp[i];
                act_shape[i] <= sh_shape[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (sample_tick) state_nx = CALC;
            CALC:    state_nx = EMIT;
            EMIT:    if (out_ready) state_nx = last_ch ? IDLE : CALC;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        phase = acc[ch][ACC_W-1 -: SAMPLE_W] + act_off[ch];
        tri_t = phase[SAMPLE_W-2:0];
        wave  = phase;
        unique case (act_shape[ch])
            2'd0: wave = phase;
            2'd1: wave = phase[SAMPLE_W-1] ? {~tri_t, 1'b0} : {tri_t, 1'b0};
            2'd2: wave = phase[SAMPLE_W-1] ? '0 : '1;
            2'd3: wave = ~phase;
        endcase
        dev  = {1'b0, wave} - (SAMPLE_W + 1)'(MID);
        // Signed deviation times unsigned gain; arithmetic shift floors
        prod = PW'(dev) * $signed(PW'({1'b0, act_amp[ch]}));
        sample_nx = SAMPLE_W'(prod >>> AMP_W) + SAMPLE_W'(MID);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch         <= '0;
            out_sample <= '0;
            out_ch     <= '0;
        end else begin
            if (tick_ok) begin
                ch <= '0;
            end else if (xfer && !last_ch) begin
                ch <= ch + CH_W'(1);
            end
            if (state == CALC) begin
                out_sample <= sample_nx;
                out_ch     <= ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (sample_tick && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dds_multichannel_core.sv
// Bench for dds_multichannel_core: directed and random bursts
// checked against an arithmetic reference model.
module tb_dds_multichannel_core;

    localparam int CHN   = 2;
    localparam int ACC_W = 24;
    localparam int SW    = 12;
    localparam int AW    = 11;
    localparam int CH_W  = 1;
    localparam int HALF  = 1 << (SW - 1);
    localparam int FULL  = (1 << SW) - 1;
    localparam int SCALE = 1 << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            sample_tick = 1'b0;
    logic            cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic [1:0]      cfg_addr = '0;
    logic [ACC_W-1:0] cfg_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [SW-1:0]   out_sample;
    logic [CH_W-1:0] out_ch;
    logic            out_last;
    logic            busy;
    logic            overrun;
    logic            overrun_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    int m_tw [CHN];
    int m_off[CHN];
    int m_amp[CHN];
    int m_shp[CHN];
    int a_off[CHN];
    int a_amp[CHN];
    int a_shp[CHN];
    int m_acc[CHN];

    dds_multichannel_core #(
        .CHANNELS(CHN), .ACC_W(ACC_W), .SAMPLE_W(SW), .AMP_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sample(out_sample),
        .out_ch(out_ch), .out_last(out_last), .busy(busy),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sample(int acc, int off, int amp, int shp);
        int p, w, prod, q;
        p = ((acc >> (ACC_W - SW)) + off) % (1 << SW);
        case (shp)
            0: w = p;
            1: w = (p < HALF) ? 2 * p : 2 * (FULL - p);
            2: w = (p < HALF) ? FULL : 0;
            default: w = FULL - p;
        endcase
        prod = (w - HALF) * amp;
        q = (prod >= 0) ? prod / SCALE : -((-prod + SCALE - 1) / SCALE);
        return HALF + q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CHN; i++) begin
            m_tw[i] = 0; m_off[i] = 0; m_amp[i] = 0; m_shp[i] = 0;
            a_off[i] = 0; a_amp[i] = 0; a_shp[i] = 0; m_acc[i] = 0;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < CHN; i++) begin
            m_acc[i] = (m_acc[i] + m_tw[i]) % (1 << ACC_W);
            a_off[i] = m_off[i];
            a_amp[i] = m_amp[i];
            a_shp[i] = m_shp[i];
        end
    endtask

    task automatic cfg(input int c, input int a, input int d);
        cfg_we   = 1'b1;
        cfg_ch   = c[CH_W-1:0];
        cfg_addr = a[1:0];
        cfg_data = d[ACC_W-1:0];
        case (a)
            0: m_tw[c]  = d & ((1 << ACC_W) - 1);
            1: m_off[c] = d & FULL;
            2: m_amp[c] = d & (SCALE - 1);
            default: m_shp[c] = d & 3;
        endcase
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic burst(input int bp, input bit ovr, input bit ovr_clr,
                         input bit mid_wr, input bit tick_wr);
        int exp_s[CHN];
        int cyc;
        logic [SW-1:0] held;
        model_tick();
        for (int i = 0; i < CHN; i++)
            exp_s[i] = ref_sample(m_acc[i], a_off[i], a_amp[i], a_shp[i]);
        sample_tick = 1'b1;
        if (tick_wr) begin
            cfg_we = 1'b1; cfg_ch = '0; cfg_addr = 2'd2; cfg_data = '0;
            m_amp[0] = 0;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        chk("busy_calc", busy, 1);
        chk("valid_calc", out_valid, 0);
        if (ovr) begin
            sample_tick = 1'b1;
            overrun_clr = ovr_clr;
        end
        if (mid_wr) begin
            cfg_we = 1'b1; cfg_ch = '0; cfg_addr = 2'd2; cfg_data = '0;
            m_amp[0] = 0;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        cfg_we = 1'b0;
        if (ovr) chk("overrun_set", overrun, 1);
        chk("valid_lat2", out_valid, 1);
        for (int k = 0; k < CHN; k++) begin
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (!out_valid) begin
                total++;
                bad++;
                $error("FAIL timeout ch=%0d observed=0 expected=1", k);
            end else begin
                chk("sample", out_sample, exp_s[k]);
                chk("ch", out_ch, k);
                chk("last", out_last, (k == CHN - 1));
                if (bp > 0) begin
                    held = out_sample;
                    out_ready = 1'b0;
                    repeat (bp) begin
                        @(negedge clk);
                        chk("hold_valid", out_valid, 1);
                        chk("hold_sample", out_sample, held);
                        chk("hold_ch", out_ch, k);
                    end
                    out_ready = 1'b1;
                end
                @(negedge clk);
                chk("drop_valid", out_valid, 0);
            end
        end
        chk("idle_after", busy, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sample", out_sample, 0);
        chk("rst_last", out_last, 0);
        rst = 1'b1;
        @(negedge clk);

        cfg(0, 0, 'h100000);
        cfg(0, 2, 2047);
        cfg(0, 3, 0);
        repeat (17) burst(0, 0, 0, 0, 0);

        cfg(1, 3, 2);
        cfg(1, 2, 1024);
        cfg(1, 0, 0);
        burst(0, 0, 0, 0, 0);
        cfg(1, 1, 2048);
        burst(0, 0, 0, 0, 0);

        burst(5, 0, 0, 0, 0);

        burst(0, 1, 0, 0, 0);
        chk("overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("overrun_clr", overrun, 0);
        burst(0, 1, 1, 0, 0);
        chk("overrun_clr_tie", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        burst(0, 0, 0, 0, 0);

        cfg(0, 2, 2047);
        burst(0, 0, 0, 1, 0);
        burst(0, 0, 0, 0, 0);
        cfg(0, 2, 2047);
        burst(0, 0, 0, 0, 1);
        burst(0, 0, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            for (int c = 0; c < CHN; c++) begin
                cfg(c, 0, int'($urandom_range(0, (1 << ACC_W) - 1)));
                cfg(c, 1, int'($urandom_range(0, FULL)));
                cfg(c, 2, int'($urandom_range(0, SCALE - 1)));
                cfg(c, 3, int'($urandom_range(0, 3)));
            end
            repeat (int'($urandom_range(1, 3)))
                burst(int'($urandom_range(0, 3)), 0, 0, 0, 0);
        end

        burst(0, 1, 0, 0, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_sample", out_sample, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_quiet", out_valid, 0);
        end
        cfg(0, 0, 'h234567);
        cfg(0, 2, 1500);
        cfg(1, 0, 'h0abcde);
        cfg(1, 2, 900);
        cfg(1, 3, 1);
        burst(2, 0, 0, 0, 0);
        burst(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
